// File: rtl/ldext_pkg.sv
// Shared encodings for the sub-word load sequencer: access sizes, FSM states, default timeout.
// Optional build macro LOAD_EXT_UNALIGNED_TRAP_EN enables the misalignment trap in load_ext_ctrl.
package ldext_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } LdState;

    // Encoding 2'b11 behaves as a word access, so it traps like one.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addrLo[0];
            default: bad = (addrLo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_ext_ctrl_if.sv
// Request, data-memory and response signals of the load sequencer.
// master is the sequencer's view; slave is the surrounding pipeline/memory view.
interface load_ext_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [4:0]  req_rd;

    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    logic        busy;

    modport master (
        input  req_valid, req_addr, req_size, req_signed, req_rd,
        input  mem_rvalid, mem_rdata,
        input  rsp_ready,
        output req_ready,
        output mem_rd_en, mem_addr,
        output rsp_valid, rsp_data, rsp_rd, rsp_err,
        output busy
    );

    modport slave (
        output req_valid, req_addr, req_size, req_signed, req_rd,
        output mem_rvalid, mem_rdata,
        output rsp_ready,
        input  req_ready,
        input  mem_rd_en, mem_addr,
        input  rsp_valid, rsp_data, rsp_rd, rsp_err,
        input  busy
    );

endinterface

// File: rtl/ldext_align.sv
// Combinational lane select and sign/zero extension of a little-endian read word.
module ldext_align
    import ldext_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        isSigned,
    output logic [31:0] extData
);

    logic [7:0]  lane [4];
    logic [15:0] halfSel;
    logic [7:0]  byteSel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    always_comb begin
        byteSel = lane[addrLo];
        halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];
        extData = rdata;
        case (size)
            SZ_BYTE: extData = {{24{isSigned & byteSel[7]}}, byteSel};
            SZ_HALF: extData = {{16{isSigned & halfSel[15]}}, halfSel};
            default: extData = rdata;
        endcase
    end

endmodule

// File: rtl/load_ext_ctrl.sv
// Single-outstanding sub-word load sequencer: issue aligned read, wait (with timeout), extend, respond.
// Build macro LOAD_EXT_UNALIGNED_TRAP_EN: misaligned half/word requests answer immediately with an error.
module load_ext_ctrl
    import ldext_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic             clk,
    input logic             rst_n,
    load_ext_ctrl_if.master bus
);

    LdState      stateReg;
    LdState      stateNext;
    logic [31:0] addrReg;
    logic [1:0]  sizeReg;
    logic        signedReg;
    logic [4:0]  rdReg;
    logic [7:0]  cntReg;
    logic [31:0] rspDataReg;
    logic        rspErrReg;

    logic [31:0] alignData;
    logic        trap;
    logic        timeoutHit;

`ifdef LOAD_EXT_UNALIGNED_TRAP_EN
    assign trap = isMisaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Counter holds the number of WAIT cycles already spent without read data.
    assign timeoutHit = (cntReg == 8'(TIMEOUT - 1));

    ldext_align u_align (
        .rdata    (bus.mem_rdata),
        .addrLo   (addrReg[1:0]),
        .size     (sizeReg),
        .isSigned (signedReg),
        .extData  (alignData)
    );

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (bus.req_valid) stateNext = trap ? RESP : ISSUE;
            ISSUE:   stateNext = WAIT;
            WAIT:    if (bus.mem_rvalid || timeoutHit) stateNext = RESP;
            RESP:    if (bus.rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg   <= IDLE;
            addrReg    <= '0;
            sizeReg    <= SZ_BYTE;
            signedReg  <= 1'b0;
            rdReg      <= '0;
            cntReg     <= '0;
            rspDataReg <= '0;
            rspErrReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: begin
                    if (bus.req_valid) begin
                        addrReg   <= bus.req_addr;
                        sizeReg   <= bus.req_size;
                        signedReg <= bus.req_signed;
                        rdReg     <= bus.req_rd;
                        if (trap) begin
                            rspDataReg <= '0;
                            rspErrReg  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    cntReg <= '0;
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        rspDataReg <= alignData;
                        rspErrReg  <= 1'b0;
                    end else if (timeoutHit) begin
                        rspDataReg <= '0;
                        rspErrReg  <= 1'b1;
                    end else begin
                        cntReg <= cntReg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every output is a register or a decode of the state register.
    assign bus.req_ready = (stateReg == IDLE);
    assign bus.busy      = (stateReg != IDLE);
    assign bus.mem_rd_en = (stateReg == ISSUE);
    assign bus.mem_addr  = {addrReg[31:2], 2'b00};
    assign bus.rsp_valid = (stateReg == RESP);
    assign bus.rsp_data  = rspDataReg;
    assign bus.rsp_rd    = rdReg;
    assign bus.rsp_err   = rspErrReg;

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Directed and randomized bench for load_ext_ctrl against an arithmetic reference model.
module tb_load_ext_ctrl;
    import ldext_pkg::*;

    localparam int TO = 4;

`ifdef LOAD_EXT_UNALIGNED_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passCnt = 0;
    int   failCnt = 0;
    int   totalCnt = 0;

    load_ext_ctrl_if bus();

    load_ext_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: shift the addressed lane down, mask, then wrap to negative when signed.
    function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] size,
                                            input logic sgn, input logic [31:0] rdata);
        int unsigned sh;
        logic [31:0] v;
        logic [1:0]  lo;
        lo = addr[1:0];
        v  = rdata;
        if (size == 2'b00) begin
            sh = 8 * lo;
            v  = (rdata >> sh) & 32'h0000_00FF;
            if (sgn && v >= 32'h80) v = v - 32'h100;
        end else if (size == 2'b01) begin
            sh = lo[1] ? 16 : 0;
            v  = (rdata >> sh) & 32'h0000_FFFF;
            if (sgn && v >= 32'h8000) v = v - 32'h1_0000;
        end
        return v;
    endfunction

    function automatic bit refTrap(input logic [31:0] addr, input logic [1:0] size);
        logic [1:0] lo;
        lo = addr[1:0];
        if (!TRAP_EN) return 1'b0;
        if (size == 2'b01) return lo[0];
        if (size[1]) return lo != 2'b00;
        return 1'b0;
    endfunction

    task automatic doLoad(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [4:0] rd, input logic [31:0] rdata,
                          input int lat, input int stall);
        logic [31:0] expData;
        bit          trap;
        trap    = refTrap(addr, size);
        expData = trap ? 32'h0 : refLoad(addr, size, sgn, rdata);
        check1({tag, ".idle_rdy"}, bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_rd     = rd;
        tick();
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_rd     = 5'($urandom);
        if (trap) begin
            check1({tag, ".trap_no_rd"}, bus.mem_rd_en, 1'b0);
        end else begin
            check1({tag, ".rd_en"}, bus.mem_rd_en, 1'b1);
            check32({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            tick();
            for (int i = 0; i < lat; i++) begin
                check1({tag, ".wait_nrsp"}, bus.rsp_valid, 1'b0);
                tick();
            end
            check1({tag, ".wait_busy"}, bus.busy, 1'b1);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            tick();
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
        end
        check1({tag, ".rsp_valid"}, bus.rsp_valid, 1'b1);
        check32({tag, ".rsp_data"}, bus.rsp_data, expData);
        check1({tag, ".rsp_err"}, bus.rsp_err, trap);
        check32({tag, ".rsp_rd"}, 32'(bus.rsp_rd), 32'(rd));
        for (int i = 0; i < stall; i++) begin
            bus.rsp_ready = 1'b0;
            bus.req_valid = 1'b1;
            tick();
            check1({tag, ".stall_valid"}, bus.rsp_valid, 1'b1);
            check32({tag, ".stall_data"}, bus.rsp_data, expData);
            check32({tag, ".stall_rd"}, 32'(bus.rsp_rd), 32'(rd));
            check1({tag, ".stall_nrdy"}, bus.req_ready, 1'b0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check1({tag, ".done_nrsp"}, bus.rsp_valid, 1'b0);
        check1({tag, ".done_rdy"}, bus.req_ready, 1'b1);
        $display("load %s addr=%08h size=%0d sgn=%0d rd=%0d rdata=%08h lat=%0d stall=%0d -> exp %08h",
                 tag, addr, size, sgn, rd, rdata, lat, stall, expData);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = '0;
        bus.req_signed = 1'b0;
        bus.req_rd     = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.rsp_ready  = 1'b0;

        rst_n = 1'b0;
        tick();
        tick();
        check1("rst.req_ready", bus.req_ready, 1'b1);
        check1("rst.busy", bus.busy, 1'b0);
        check1("rst.rd_en", bus.mem_rd_en, 1'b0);
        check1("rst.rsp_valid", bus.rsp_valid, 1'b0);
        check1("rst.rsp_err", bus.rsp_err, 1'b0);
        check32("rst.rsp_data", bus.rsp_data, 32'h0);
        check32("rst.rsp_rd", 32'(bus.rsp_rd), 32'h0);
        check32("rst.mem_addr", bus.mem_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        doLoad("byte_s", 32'h0000_1003, SZ_BYTE, 1'b1, 5'd3, 32'h80FF_1234, 0, 0);
        doLoad("half_u", 32'h0000_2002, SZ_HALF, 1'b0, 5'd4, 32'hBEEF_0000, 0, 0);
        doLoad("half_s", 32'h0000_2002, SZ_HALF, 1'b1, 5'd5, 32'hBEEF_0000, 0, 0);
        doLoad("bp5",    32'h0000_2000, SZ_HALF, 1'b1, 5'd6, 32'h1234_8001, 1, 5);
        doLoad("after_bp", 32'h0000_2001, SZ_BYTE, 1'b0, 5'd7, 32'h1234_8001, 0, 0);
        doLoad("lat_max", 32'h0000_5002, SZ_BYTE, 1'b1, 5'd8, 32'h00C3_0000, TO - 1, 0);
        doLoad("mis_word", 32'h0000_3001, SZ_WORD, 1'b1, 5'd9, 32'hAABB_CCDD, 0, 0);
        doLoad("mis_half", 32'h0000_3003, SZ_HALF, 1'b1, 5'd10, 32'hAABB_CCDD, 0, 1);
        doLoad("size11", 32'h0000_3000, 2'b11, 1'b1, 5'd11, 32'h8000_0001, 0, 0);

        // Timeout with no read data, late rvalid while in RESP, stray rvalid while idle.
        check1("to.idle_rdy", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_4000;
        bus.req_size  = SZ_WORD;
        bus.req_rd    = 5'd21;
        tick();
        bus.req_valid = 1'b0;
        check1("to.rd_en", bus.mem_rd_en, 1'b1);
        tick();
        for (int k = 0; k < TO; k++) begin
            check1("to.wait_nrsp", bus.rsp_valid, 1'b0);
            tick();
        end
        check1("to.rsp_valid", bus.rsp_valid, 1'b1);
        check1("to.rsp_err", bus.rsp_err, 1'b1);
        check32("to.rsp_data", bus.rsp_data, 32'h0);
        check32("to.rsp_rd", 32'(bus.rsp_rd), 32'd21);
        tick();
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        tick();
        bus.mem_rvalid = 1'b0;
        check1("to.late_valid", bus.rsp_valid, 1'b1);
        check1("to.late_err", bus.rsp_err, 1'b1);
        check32("to.late_data", bus.rsp_data, 32'h0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        check1("to.idle_rv_rdy", bus.req_ready, 1'b1);
        check1("to.idle_rv_nrsp", bus.rsp_valid, 1'b0);
        $display("timeout load rd=21 TIMEOUT=%0d checked", TO);

        // Reset pulse while waiting for read data.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_6004;
        bus.req_size  = SZ_BYTE;
        bus.req_rd    = 5'd30;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check1("rstw.busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check1("rstw.req_ready", bus.req_ready, 1'b1);
        check1("rstw.rsp_valid", bus.rsp_valid, 1'b0);
        check1("rstw.busy", bus.busy, 1'b0);
        check32("rstw.mem_addr", bus.mem_addr, 32'h0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        tick();
        bus.mem_rvalid = 1'b0;
        tick();
        check1("rstw.late_nrsp", bus.rsp_valid, 1'b0);
        check1("rstw.late_rdy", bus.req_ready, 1'b1);
        check1("rstw.late_nrd", bus.mem_rd_en, 1'b0);
        $display("reset during wait checked");

        for (int n = 0; n < 40; n++) begin
            doLoad($sformatf("rnd%0d", n), $urandom, 2'($urandom), 1'($urandom), 5'($urandom),
                   $urandom, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
